div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 28 ++
 rtl/div_unit.sv | 155 +++++++++++++++
 tb/tb_div_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared constants for the iterative divider.
//   div_op_e     - operation encodings (DIV, DIVU, REM, REMU)
//   div_state_e  - controller states (IDLE, BUSY, DONE)
//   op_is_signed / op_is_rem - operation decode helpers
package div_unit_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } div_state_e;

  function automatic logic op_is_signed(div_op_e o);
    return (o == OP_DIV) || (o == OP_REM);
  endfunction

  function automatic logic op_is_rem(div_op_e o);
    return (o == OP_REM) || (o == OP_REMU);
  endfunction

endpackage

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider, one quotient bit per cycle.
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   start    in   request a divide (sampled only in IDLE)
//   op       in   DIV / DIVU / REM / REMU
//   dividend in   numerator
//   divisor  in   denominator
//   flush    in   abort the in-flight operation
//   divcy    out  busy, used to stall the ID stage
//   done     out  one-cycle pulse, result valid
//   result   out  quotient or remainder, held until the next accepted start
//   trapdiv  out  divide-by-zero trap pulse (with done)
// Build option: define DIV_ZERO_TRAP_EN to raise trapdiv on DIV/DIVU by zero;
// otherwise trapdiv is tied low.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            divcy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            trapdiv
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] result_q, result_d;
  logic            qneg_q, rneg_q, is_rem_q, dz_q, ovf_q, done_q;

  // Operand decode at the start cycle
  div_op_e         op_e;
  logic            sgn, dz, ovf;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    op_e  = div_op_e'(op);
    sgn   = op_is_signed(op_e);
    a_mag = (sgn && dividend[XLEN-1]) ? -dividend : dividend;
    b_mag = (sgn && divisor[XLEN-1])  ? -divisor  : divisor;
    dz    = (divisor == '0);
    ovf   = sgn && (dividend == SMIN) && (divisor == '1);
  end

  // One restoring step; the extra top bit of the difference is its sign.
  logic [XLEN+1:0] shift_w, diff_w;

  always_comb begin
    shift_w = {rem_q, quo_q[XLEN-1]};
    diff_w  = shift_w - {2'b00, dvs_q};
    if (diff_w[XLEN+1]) begin
      rem_d = shift_w[XLEN:0];
      quo_d = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_d = diff_w[XLEN:0];
      quo_d = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  // Final result. On the fast path quo_q still holds the undisturbed dividend
  // magnitude, so re-applying the dividend sign yields the dividend itself.
  logic            fast;
  logic [XLEN-1:0] q_mag, r_mag, q_fix, r_fix;

  always_comb begin
    fast     = dz_q | ovf_q;
    q_mag    = fast ? (ovf_q ? SMIN : '1) : quo_d;
    r_mag    = fast ? (ovf_q ? '0 : quo_q) : rem_d[XLEN-1:0];
    q_fix    = (qneg_q && !fast) ? -q_mag : q_mag;
    r_fix    = rneg_q ? -r_mag : r_mag;
    result_d = is_rem_q ? r_fix : q_fix;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      is_rem_q <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              rem_q    <= '0;
              quo_q    <= a_mag;
              dvs_q    <= b_mag;
              cnt_q    <= CW'(XLEN);
              qneg_q   <= sgn && (dividend[XLEN-1] ^ divisor[XLEN-1]);
              rneg_q   <= sgn && dividend[XLEN-1];
              is_rem_q <= op_is_rem(op_e);
              dz_q     <= dz;
              ovf_q    <= ovf;
              state_q  <= S_BUSY;
            end
          end
          S_BUSY: begin
            if (fast) begin
              result_q <= result_d;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              rem_q <= rem_d;
              quo_q <= quo_d;
              cnt_q <= cnt_q - CW'(1);
              if (cnt_q == CW'(1)) begin
                result_q <= result_d;
                done_q   <= 1'b1;
                state_q  <= S_DONE;
              end
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign divcy  = ~reset & ~flush &
                  ((start & (state_q == S_IDLE)) | (state_q == S_BUSY));
  assign done   = done_q;
  assign result = result_q;

`ifdef DIV_ZERO_TRAP_EN
  assign trapdiv = done_q & dz_q & ~is_rem_q;
`else
  assign trapdiv = 1'b0;
`endif

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors for div_unit with a queue-based scoreboard.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        flush = 1'b0;
  logic        divcy, done, trapdiv;
  logic [31:0] result;

  div_unit #(.XLEN(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .dividend(dividend),
    .divisor (divisor),
    .flush   (flush),
    .divcy   (divcy),
    .done    (done),
    .result  (result),
    .trapdiv (trapdiv)
  );

  always #5 clock = ~clock;

`ifdef DIV_ZERO_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    logic        trap;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   ndone = 0;

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected entry.
  always @(negedge clock) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("trapdiv", {31'd0, trapdiv}, {31'd0, e.trap});
        chk("latency", cyc - e.start_cyc, e.lat);
      end
      ndone++;
    end
  end

  // Issue one operation, scramble operands while busy, then wait (bounded)
  // for done and check how many cycles divcy was high (equals the latency).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_trap, input int lat);
    exp_t e;
    int   prev, busy_cnt;
    logic seen;
    @(negedge clock);
    op = o; dividend = a; divisor = b; start = 1'b1;
    e.res = exp_res; e.trap = exp_trap; e.start_cyc = cyc; e.lat = lat;
    sb.push_back(e);
    prev = ndone;
    #1;
    busy_cnt = divcy ? 1 : 0;
    @(negedge clock);
    start = 1'b0;
    dividend = $urandom; divisor = $urandom; op = 2'($urandom);
    seen = 1'b0;
    #2;
    for (int i = 0; i < 60; i++) begin
      if (ndone != prev) begin seen = 1'b1; break; end
      if (divcy) busy_cnt++;
      @(negedge clock);
      #2;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("divcy_cycles", busy_cnt, lat);
  endtask

  // Start an operation that is expected never to complete.
  task automatic start_nochk(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    op = o; dividend = a; divisor = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    // Reset state
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_trap", {31'd0, trapdiv}, 32'd0);
    chk("rst_divcy", {31'd0, divcy}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 33);
    run_op(OP_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 33);
    run_op(OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 33);
    run_op(OP_DIV,  32'd5, 32'd0, 32'hFFFFFFFF, TRAP, 2);
    run_op(OP_REMU, 32'd5, 32'd0, 32'd5, 1'b0, 2);
    run_op(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 2);
    run_op(OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 2);
    run_op(OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1'b0, 33);
    run_op(OP_DIV,  32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33);
    run_op(OP_REM,  32'd7, 32'hFFFFFFFE, 32'd1, 1'b0, 33);
    run_op(OP_REMU, 32'hFFFFFFFF, 32'h10, 32'hF, 1'b0, 33);
    run_op(OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 33);
    run_op(OP_REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33);
    run_op(OP_DIV,  32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, TRAP, 2);
    run_op(OP_REM,  32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1'b0, 2);
    run_op(OP_DIVU, 32'd3, 32'd0, 32'hFFFFFFFF, TRAP, 2);

    // Flush at cycle 10 of a DIVU: no done, result unchanged, IDLE after.
    held = 32'hFFFFFFFF;
    start_nochk(OP_DIVU, 32'd1000, 32'd3);
    repeat (8) @(negedge clock);
    flush = 1'b1;
    #1;
    chk("flush_divcy", {31'd0, divcy}, 32'd0);
    @(negedge clock);
    flush = 1'b0;
    #1;
    chk("post_flush_divcy", {31'd0, divcy}, 32'd0);
    repeat (40) @(negedge clock);
    chk("flush_result_held", result, held);
    run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 33);

    // Reset at cycle 5 of BUSY: immediate clear, no done afterwards.
    start_nochk(OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst_divcy", {31'd0, divcy}, 32'd0);
    chk("midrst_result", result, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);

    // start together with flush in IDLE is not accepted.
    op = OP_DIVU; dividend = 32'd50; divisor = 32'd5;
    start = 1'b1; flush = 1'b1;
    #1;
    chk("startflush_divcy", {31'd0, divcy}, 32'd0);
    @(negedge clock);
    start = 1'b0; flush = 1'b0;
    #1;
    chk("startflush_idle", {31'd0, divcy}, 32'd0);
    repeat (40) @(negedge clock);
    chk("startflush_result", result, 32'd0);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
